// File: rtl/vx_stream_wrr_arbiter.sv
// rtl/vx_stream_wrr_arbiter.sv - packet-aware weighted round-robin stream arbiter
//
// Merges NUM_REQS valid/ready beat streams into one registered output stream.
// A grant is held from the first beat to the last beat of a packet, so packets
// never interleave. After the packet completes, the grant can stay with the same
// requester for up to quota_in[g] packets, then it rotates.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   valid_in/data_in/last_in/ready_in   per-requester input beat handshake
//   quota_in              packets per turn for each requester (0 behaves as 1)
//   valid_out/data_out/last_out/sel_out registered output beat and source index
//   ready_out             downstream ready
module vx_stream_wrr_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int QUOTAW   = 4,
    localparam int SELW    = $clog2(NUM_REQS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQS-1:0]        valid_in,
    input  logic [NUM_REQS*DATAW-1:0]  data_in,
    input  logic [NUM_REQS-1:0]        last_in,
    output logic [NUM_REQS-1:0]        ready_in,
    input  logic [NUM_REQS*QUOTAW-1:0] quota_in,
    output logic                       valid_out,
    output logic [DATAW-1:0]           data_out,
    output logic                       last_out,
    output logic [SELW-1:0]            sel_out,
    input  logic                       ready_out
);

    // CONT: a packet just ended with quota remaining; the grant stays only if
    // the same requester is still presenting a beat in this cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        CONT   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SELW-1:0]   grant_q, grant_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [QUOTAW-1:0] cnt_q, cnt_d;

    logic              valid_q;
    logic [DATAW-1:0]  data_q;
    logic              last_q;
    logic [SELW-1:0]   sel_q;

    logic              stage_ready;
    logic              grant_en;
    logic              xfer;
    logic [SELW-1:0]   cur_idx;
    logic [SELW-1:0]   cand;
    logic [SELW-1:0]   idle_idx;
    logic              idle_found;
    logic [QUOTAW-1:0] quota_sel;
    logic [QUOTAW-1:0] quota_eff;
    logic [QUOTAW-1:0] cnt_base;
    logic [DATAW-1:0]  beat_data;

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] i);
        if (i == SELW'(NUM_REQS - 1)) begin
            return '0;
        end
        return i + SELW'(1);
    endfunction

    assign stage_ready = !valid_q || ready_out;

    // First valid requester at or after the rotation pointer, with wrap.
    always_comb begin
        idle_found = 1'b0;
        idle_idx   = ptr_q;
        cand       = ptr_q;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!idle_found && valid_in[cand]) begin
                idle_found = 1'b1;
                idle_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    // Quota is only consumed when a turn starts from IDLE.
    assign quota_sel = quota_in[int'(idle_idx)*QUOTAW +: QUOTAW];
    assign quota_eff = (quota_sel == '0) ? QUOTAW'(1) : quota_sel;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_en = 1'b0;
        cur_idx  = grant_q;
        cnt_base = cnt_q;

        case (state_q)
            IDLE: begin
                grant_en = idle_found;
                cur_idx  = idle_idx;
                cnt_base = quota_eff;
            end
            LOCKED: begin
                grant_en = 1'b1;
            end
            CONT: begin
                grant_en = 1'b1;
                if (!valid_in[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = wrap_inc(grant_q);
                end else begin
                    // Next packet has started presenting; hold it even if
                    // the output stage stalls this cycle.
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        xfer = grant_en && stage_ready && valid_in[cur_idx];

        // A grant from IDLE is committed only once a beat actually moves.
        if (xfer) begin
            grant_d = cur_idx;
            if (last_in[cur_idx]) begin
                if (cnt_base == QUOTAW'(1)) begin
                    state_d = IDLE;
                    ptr_d   = wrap_inc(cur_idx);
                end else begin
                    state_d = CONT;
                    cnt_d   = cnt_base - QUOTAW'(1);
                end
            end else begin
                state_d = LOCKED;
                cnt_d   = cnt_base;
            end
        end
    end

    always_comb begin
        ready_in = '0;
        if (grant_en && stage_ready && !reset) begin
            ready_in[cur_idx] = 1'b1;
        end
    end

    assign beat_data = data_in[int'(cur_idx)*DATAW +: DATAW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (xfer) begin
                valid_q <= 1'b1;
                data_q  <= beat_data;
                last_q  <= last_in[cur_idx];
                sel_q   <= cur_idx;
            end else if (ready_out) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign last_out  = last_q;
    assign sel_out   = sel_q;

endmodule

// File: tb/tb_vx_stream_wrr_arbiter.sv
// tb/tb_vx_stream_wrr_arbiter.sv - self-checking bench for vx_stream_wrr_arbiter
module tb_vx_stream_wrr_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   valid_in;
    logic [127:0] data_in;
    logic [3:0]   last_in;
    logic [3:0]   ready_in;
    logic [15:0]  quota_in;
    logic         valid_out;
    logic [31:0]  data_out;
    logic         last_out;
    logic [1:0]   sel_out;
    logic         ready_out;

    vx_stream_wrr_arbiter #(.NUM_REQS(4), .DATAW(32), .QUOTAW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .quota_in  (quota_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .last_out  (last_out),
        .sel_out   (sel_out),
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Source beats per requester; the same list is the expected output order.
    logic [31:0] src_d [4][64];
    bit          src_l [4][64];
    int          src_n [4];
    int          src_pos [4];
    int          exp_pos [4];
    int          pkt_len [4][16];
    int          src_pk [4];
    int          qv [4];
    int          uid = 1;

    int          bubble_pct = 0;
    int          rdy_mode = 0;
    int          cyc = 0;
    int          gaps = 0;
    bit          started = 0;
    bit          pkt_open = 0;
    int          open_sel = 0;
    bit          hold_chk = 0;
    logic [31:0] held_d;
    logic        held_l;
    logic [1:0]  held_s;
    logic [3:0]  last_ready;

    int          obs_sel [$];
    bit          obs_last [$];
    int          exp_seq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_quota(input int a, input int b, input int c, input int d);
        qv[0] = a; qv[1] = b; qv[2] = c; qv[3] = d;
        quota_in = {d[3:0], c[3:0], b[3:0], a[3:0]};
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            src_n[i] = 0; src_pos[i] = 0; exp_pos[i] = 0; src_pk[i] = 0;
        end
        obs_sel.delete();
        obs_last.delete();
        cyc = 0; gaps = 0; started = 0; pkt_open = 0; hold_chk = 0;
    endtask

    task automatic load_pkt(input int r, input int nb);
        for (int b = 0; b < nb; b++) begin
            src_d[r][src_n[r]] = {r[7:0], uid[23:0]};
            src_l[r][src_n[r]] = (b == nb - 1);
            src_n[r]++;
            uid++;
        end
        pkt_len[r][src_pk[r]] = nb;
        src_pk[r]++;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < 4; i++) begin
            if (src_pos[i] != src_n[i] || exp_pos[i] != src_n[i]) return 0;
        end
        return 1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        valid_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One cycle: drive at negedge, observe #1 later, well before the next posedge.
    task automatic step();
        int s;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (src_pos[i] < src_n[i] && $urandom_range(99) >= bubble_pct) begin
                valid_in[i] = 1'b1;
                data_in[i*32 +: 32] = src_d[i][src_pos[i]];
                last_in[i] = src_l[i][src_pos[i]];
            end else begin
                valid_in[i] = 1'b0;
                data_in[i*32 +: 32] = '0;
                last_in[i] = 1'b0;
            end
        end
        case (rdy_mode)
            0: ready_out = 1'b1;
            1: ready_out = ($urandom_range(99) < 70);
            default: ready_out = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        endcase
        #1;
        last_ready = ready_in;
        chk("onehot_ready", ($countones(ready_in) <= 1), 1);
        if (hold_chk) begin
            chk("stall_valid", valid_out, 1);
            chk("stall_data", data_out, held_d);
            chk("stall_last", last_out, held_l);
            chk("stall_sel", sel_out, held_s);
        end
        hold_chk = valid_out && !ready_out;
        held_d = data_out; held_l = last_out; held_s = sel_out;
        if (valid_out && ready_out) begin
            s = int'(sel_out);
            if (exp_pos[s] < src_n[s]) begin
                chk("beat_data", data_out, src_d[s][exp_pos[s]]);
                chk("beat_last", last_out, src_l[s][exp_pos[s]]);
                exp_pos[s]++;
            end else begin
                chk("extra_beat", exp_pos[s], src_n[s] - 1);
            end
            if (pkt_open) chk("interleave", s, open_sel);
            pkt_open = !last_out;
            open_sel = s;
            obs_sel.push_back(s);
            obs_last.push_back(last_out);
            started = 1;
        end else if (!valid_out && started && !all_done()) begin
            gaps++;
        end
        for (int i = 0; i < 4; i++) begin
            if (valid_in[i] && ready_in[i]) src_pos[i]++;
        end
        cyc++;
    endtask

    task automatic run(input int max_cycles);
        int c = 0;
        while (!all_done() && c < max_cycles) begin
            step();
            c++;
        end
        chk("drained", all_done(), 1);
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, obs_sel.size(), exp_seq.size());
        for (int k = 0; k < exp_seq.size() && k < obs_sel.size(); k++) begin
            chk(tag, obs_sel[k], exp_seq[k]);
        end
    endtask

    // Turn-level reference: each turn serves min(quota, pending) whole packets
    // from the first pending requester at or after the pointer.
    task automatic build_model();
        int nxt [4];
        int left = 0;
        int p = 0;
        int g;
        int q;
        exp_seq.delete();
        for (int i = 0; i < 4; i++) begin
            nxt[i] = 0;
            left += src_pk[i];
        end
        while (left > 0) begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && nxt[(p + k) % 4] < src_pk[(p + k) % 4]) g = (p + k) % 4;
            end
            q = (qv[g] == 0) ? 1 : qv[g];
            for (int t = 0; t < q && nxt[g] < src_pk[g]; t++) begin
                for (int b = 0; b < pkt_len[g][nxt[g]]; b++) exp_seq.push_back(g);
                nxt[g]++;
                left--;
            end
            p = (g + 1) % 4;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        valid_in = '0; data_in = '0; last_in = '0; ready_out = 1'b1;
        set_quota(1, 1, 1, 1);
        bubble_pct = 0; rdy_mode = 0;

        // Reset held with all requesters valid.
        clear_src();
        for (int i = 0; i < 4; i++) load_pkt(i, 1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_in[i] = 1'b1;
            data_in[i*32 +: 32] = src_d[i][0];
            last_in[i] = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("rst_valid_out", valid_out, 0);
            chk("rst_ready_in", ready_in, 0);
        end
        reset = 1'b0;
        valid_in = '0;
        run(100);
        exp_seq = '{0, 1, 2, 3};
        chk_seq("rst_order");

        // Interleave guard.
        clear_src(); do_reset();
        set_quota(1, 1, 1, 1);
        load_pkt(0, 3); load_pkt(1, 1); load_pkt(1, 1);
        run(100);
        exp_seq = '{0, 0, 0, 1, 1};
        chk_seq("ilv_sel");
        if (obs_last.size() >= 4) begin
            chk("ilv_last0", obs_last[0], 0);
            chk("ilv_last1", obs_last[1], 0);
            chk("ilv_last2", obs_last[2], 1);
            chk("ilv_last3", obs_last[3], 1);
        end

        // Quota of two packets per turn.
        clear_src(); do_reset();
        set_quota(2, 2, 2, 2);
        for (int k = 0; k < 4; k++) load_pkt(0, 1);
        for (int i = 1; i < 4; i++) begin
            load_pkt(i, 1); load_pkt(i, 1);
        end
        run(100);
        exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        chk_seq("quota_sel");
        chk("quota_gaps", gaps, 0);

        // Quota zero behaves as one.
        clear_src(); do_reset();
        set_quota(1, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            load_pkt(0, 1); load_pkt(1, 1);
        end
        run(100);
        exp_seq = '{0, 1, 0, 1, 0, 1};
        chk_seq("quota0_sel");

        // Backpressure during a 4-beat packet.
        clear_src(); do_reset();
        set_quota(1, 1, 1, 1);
        rdy_mode = 2;
        load_pkt(2, 4);
        run(100);
        exp_seq = '{2, 2, 2, 2};
        chk_seq("bp_sel");
        rdy_mode = 0;

        // Reset in the middle of a packet.
        clear_src(); do_reset();
        load_pkt(3, 4);
        for (int c = 0; c < 20 && src_pos[3] < 2; c++) step();
        chk("mid_two_beats", src_pos[3], 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_ready", ready_in, 0);
        reset = 1'b0;
        valid_in = '0;
        src_n[3] = src_pos[3];
        exp_pos[3] = src_n[3];
        obs_sel.delete(); obs_last.delete();
        pkt_open = 0; hold_chk = 0; started = 0;
        load_pkt(0, 1); load_pkt(1, 1); load_pkt(3, 1);
        step();
        chk("mid_first_grant", last_ready, 4'b0001);
        run(100);
        exp_seq = '{0, 1, 3};
        chk_seq("mid_order");

        // Randomized rounds: without bubbles the turn-level model predicts the
        // exact source order; with bubbles only integrity is checked.
        for (int r = 0; r < 8; r++) begin
            clear_src(); do_reset();
            set_quota($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
            for (int i = 0; i < 4; i++) begin
                int np = $urandom_range(5);
                for (int p = 0; p < np; p++) load_pkt(i, $urandom_range(1, 4));
            end
            bubble_pct = (r % 2 == 0) ? 0 : 30;
            rdy_mode = 1;
            run(3000);
            if (bubble_pct == 0) begin
                build_model();
                chk_seq("rand_wrr");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_stream_wrr_arbiter.md
Name: vx_stream_wrr_arbiter

Overview:
- Packet-aware weighted round-robin arbiter merging NUM_REQS valid/ready streams into one output stream.
- A grant is held for a whole packet, delimited by last_in, so beats of different packets never interleave.
- Each requester may send up to quota_in[i] consecutive packets before the grant rotates.
- Sits in front of shared memory/cache request ports where multi-beat transfers must stay contiguous; the output is registered.

Parameters:
- NUM_REQS, 4, number of requesters (>=2).
- DATAW, 32, payload width per beat.
- QUOTAW, 4, width of per-requester packet quota.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_in  in  NUM_REQS  per-requester beat valid
- data_in  in  NUM_REQS*DATAW  per-requester beat payload
- last_in  in  NUM_REQS  beat is last of packet
- ready_in  out  NUM_REQS  per-requester beat accepted
- quota_in  in  NUM_REQS*QUOTAW  packets allowed per turn; 0 treated as 1
- valid_out  out  1  output beat valid (registered)
- data_out  out  DATAW  output payload (registered)
- last_out  out  1  output last flag (registered)
- sel_out  out  log2(NUM_REQS)  index of requester that sourced the output beat (registered)
- ready_out  in  1  downstream ready

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - valid_out=0, data_out=0, last_out=0, sel_out=0.
  - state=IDLE, rr pointer=0, packet counter=0.
  - ready_in=0 while reset is high.
- Output stage:
  - Single register; stage_ready = !valid_out || ready_out.
  - A beat accepted in cycle N appears on valid_out in cycle N+1.
  - Full throughput of 1 beat/cycle under continuous ready_out.
- Beat acceptance: ready_in[g] = stage_ready && grant[g]. A beat transfers when valid_in[g] && ready_in[g]; otherwise ready_in[i]=0.
- IDLE:
  - Selects the first valid requester searching from pointer upward, wrapping modulo NUM_REQS.
  - Grant is combinational in the same cycle, so a beat may transfer in the IDLE cycle.
  - Latches g, loads cnt = max(quota_in[g],1).
  - If the transferred beat has last_in=0, goes to LOCKED.
  - If last_in=1, applies the packet-end rule below.
  - No valid request: stays IDLE with ready_in=0.
- LOCKED:
  - Grant fixed to g. Other requesters get ready_in=0 even if valid.
  - A bubble (valid_in[g]=0) holds the lock; no timeout.
- Packet-end rule, on a transfer with last_in[g]=1: cnt decrements.
  - If cnt reaches 0, or valid_in[g] is 0 in the following cycle: pointer = (g+1) mod NUM_REQS, go to IDLE.
  - Otherwise stay granted to g for the next packet (CONT). CONT is equivalent to LOCKED with a preserved counter.
- Quota sampling: quota_in is sampled only when a grant is issued from IDLE. Later changes do not affect the current turn.
- Single-beat packets: each counts as one packet.
- Downstream stall: when ready_out=0 with valid_out=1, data_out/last_out/sel_out hold stable and no beat transfers.
- Reset mid-packet: discards the lock, counter and output register. No beat is emitted from the partial packet after reset.
- Data selection: data_in[g] is muxed to the register only on transfer.
- Invariants:
  - At most one ready_in bit is high per cycle.
  - valid_in dropping without a transfer is legal; the arbiter never re-arbitrates mid-packet.

Test Plan:
- Reset: hold reset 3 cycles with all valid_in=1 -> valid_out=0, ready_in=0; first grant afterwards goes to requester 0.
- Interleave guard: req0 sends a 3-beat packet while req1 is continuously valid with single-beat packets -> output sel_out sequence is 0,0,0 then 1. Output last_out is high only on beat 3 and on req1's beat.
- Quota: all quota_in=2, all four requesters continuously valid with single-beat packets, ready_out=1 -> sel_out sequence 0,0,1,1,2,2,3,3,0,0. Valid_out is high every cycle after first.
- Quota zero: quota_in[1]=0 with req0/req1 always valid, quota_in[0]=1 -> sel_out alternates 0,1,0,1.
- Backpressure: ready_out toggles 1,0,0,1 during a 4-beat packet from req2 -> all 4 beats delivered in order with no duplication or loss. data_out is stable during stalls.
- Reset mid-packet: assert reset after beat 2 of a 4-beat packet from req3 -> valid_out=0 next cycle. After release, a valid req0 is granted immediately and pointer=0 ordering resumes.
